bcd_seg_tracker: RTL and testbench
==================================

# bcd_seg_tracker

Receive-side companion to the team's loadable BCD counter: samples the counter's 8-bit seven-segment output each enabled cycle and decodes it back to a 4-bit BCD digit. Tracks the expected 0→9→0 counting sequence, flags illegal patterns and sequence breaks (loads, resets, glitches), and counts errors and decade wraps. Sits beside the counter as an on-chip monitor for self-check and bring-up.

## Interface
- `LOCK_CNT`, default 2: consecutive correct increments required to enter LOCKED.
- `CNT_W`, default 8: width of `err_count` and `wrap_count`.
- `clk` in 1: single clock, rising edge.
- `rst_syn` in 1: reset, asynchronous, active-low.
- `sample_en` in 1: sample `seg_in` this cycle; when low, all state holds.
- `seg_in` in 8: segment pattern `{dp,g,f,e,d,c,b,a}`, active-high.
- `digit_out` out 4: last legally decoded digit.
- `digit_valid` out 1: one-cycle pulse; `digit_out` updated from a legal pattern.
- `locked` out 1: high in state LOCKED.
- `code_err` out 1: one-cycle pulse; sampled pattern is illegal.
- `seq_err` out 1: one-cycle pulse; legal digit ≠ previous+1 (mod 10) while locked.
- `wrap_pulse` out 1: one-cycle pulse; 9→0 transition seen while locked.
- `err_count` out CNT_W: total `code_err` + `seq_err` events, saturating.
- `wrap_count` out CNT_W: total `wrap_pulse` events, saturating.

## Operation
- Decode, dp ignored, pattern `seg_in[6:0]`: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F. Any other value is illegal.
- Legal sample: `digit_out` ← decoded value, `digit_valid`=1. Illegal sample: `digit_out` holds, `code_err`=1, FSM → HUNT.
- FSM states:
  - HUNT: first legal sample stores the digit as prev → ACQ with streak=0.
  - ACQ:
    - legal == prev+1 mod 10: streak+1. When streak reaches LOCK_CNT → LOCKED.
    - legal ≠ prev+1: streak=0, stay in ACQ. No `seq_err` outside LOCKED.
  - LOCKED:
    - legal == prev+1: stay. If prev=9 and new=0, `wrap_pulse`=1.
    - legal ≠ prev+1 (incl. repeat of same digit): `seq_err`=1 → ACQ, streak=0.
- prev always updates to each legal digit.
- Illegal pattern in any state: `code_err` → HUNT. At most one of `code_err`/`seq_err` per cycle.
- `err_count` increments by 1 on either error pulse. `wrap_count` increments by 1 on `wrap_pulse`. Both saturate at 2^CNT_W−1; no wrap-around.
- Increment arithmetic is mod-10 on 4 bits: 9+1 = 0.

## Timing
- Reset values: `digit_out`=0, `digit_valid`=0, `locked`=0, `code_err`=0, `seq_err`=0, `wrap_pulse`=0, `err_count`=0, `wrap_count`=0, state=HUNT, streak=0, prev=0.
- Latency: `seg_in` sampled at edge N (with `sample_en`=1) → all pulses and `digit_out` valid after edge N, for exactly one cycle. All outputs are registered.
- `locked` rises in the same cycle as the `digit_valid` of the LOCK_CNT-th correct increment. It falls in the same cycle as `seq_err`/`code_err`.
- Pulses are cleared on any cycle with `sample_en`=0.
- `rst_syn` asserted mid-sequence: immediate asynchronous clear to reset values. Counters are lost.

## Structure
- Package `bcd_seg_pkg`:
  - ten segment constants `SEG_0`..`SEG_9`
  - state enum `{HUNT, ACQ, LOCKED}`
  - `bcd_inc` mod-10 function
- Sub-module `seg7_to_bcd`: combinational, `seg_in[6:0]` → `{legal, digit[3:0]}`.
- Top holds the FSM, prev/streak registers, and saturating counters.

## Test plan
- Reset, then feed 0x3F,0x06,0x5B,0x4F with `sample_en`=1 → `digit_out` 0,1,2,3. `locked` rises with digit 2 (LOCK_CNT=2). No errors.
- Locked stream …0x7F(8),0x6F(9),0x3F(0) → `wrap_pulse` on the 0 sample, `wrap_count`=1.
- Locked at 3, then feed 0x5B (load of 2) → `seq_err` 1 cycle, `locked`=0, `err_count`=1. Then 3,4 → relock.
- Feed 0x00 mid-stream → `code_err`, `digit_out` holds previous value, state HUNT, `locked`=0.
- `sample_en`=0 for 5 cycles with `seg_in` toggling garbage → no pulses, all counts unchanged.
- Force 255 errors, then 1 more → `err_count` stays 255. Pull `rst_syn` low between edges → all outputs 0 immediately.

Source files
------------

// File: rtl/bcd_seg_pkg.sv
// bcd_seg_pkg: shared segment constants, tracker states and mod-10 helper
package bcd_seg_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  typedef enum logic [1:0] {HUNT, ACQ, LOCKED} state_t;

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// seg7_to_bcd: combinational seven-segment pattern to BCD digit decoder
module seg7_to_bcd
  import bcd_seg_pkg::*;
(
  input  logic [6:0] seg_in,
  output logic       legal,
  output logic [3:0] digit
);

  // map each of the ten legal patterns to its digit; anything else is illegal
  always_comb begin
    legal = 1'b1;
    digit = 4'd0;
    case (seg_in)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/bcd_seg_tracker.sv
// bcd_seg_tracker: decodes sampled 7-seg digits and tracks the 0..9 counting sequence
module bcd_seg_tracker
  import bcd_seg_pkg::*;
#(
  parameter int LOCK_CNT = 2,
  parameter int CNT_W    = 8
)(
  input  logic             clk,
  input  logic             rst_syn,
  input  logic             sample_en,
  input  logic [7:0]       seg_in,
  output logic [3:0]       digit_out,
  output logic             digit_valid,
  output logic             locked,
  output logic             code_err,
  output logic             seq_err,
  output logic             wrap_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] wrap_count
);

  localparam int SW = $clog2(LOCK_CNT + 1);

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_prev, w_prev_nxt;
  logic [3:0]      r_digit, w_digit_nxt;
  logic [SW-1:0]   r_streak, w_streak_nxt, w_streak_inc;
  logic            r_valid, r_cerr, r_serr, r_wrap;
  logic            w_valid_nxt, w_cerr_nxt, w_serr_nxt, w_wrap_nxt;
  logic [CNT_W-1:0] r_err_cnt, r_wrap_cnt;
  logic            w_legal, w_inc_ok, w_unused_dp;
  logic [3:0]      w_dec;

  seg7_to_bcd u_dec (
    .seg_in (seg_in[6:0]),
    .legal  (w_legal),
    .digit  (w_dec)
  );

  assign w_unused_dp  = seg_in[7];
  assign w_inc_ok     = (w_dec == bcd_inc(r_prev));
  assign w_streak_inc = r_streak + SW'(1);

  // next-state and next-pulse logic; pulses default low so idle cycles clear them
  always_comb begin
    w_state_nxt  = r_state;
    w_prev_nxt   = r_prev;
    w_digit_nxt  = r_digit;
    w_streak_nxt = r_streak;
    w_valid_nxt  = 1'b0;
    w_cerr_nxt   = 1'b0;
    w_serr_nxt   = 1'b0;
    w_wrap_nxt   = 1'b0;
    if (sample_en) begin
      if (!w_legal) begin
        w_cerr_nxt   = 1'b1;
        w_state_nxt  = HUNT;
        w_streak_nxt = '0;
      end else begin
        w_valid_nxt = 1'b1;
        w_digit_nxt = w_dec;
        w_prev_nxt  = w_dec;
        case (r_state)
          HUNT: begin
            w_state_nxt  = ACQ;
            w_streak_nxt = '0;
          end
          ACQ: begin
            w_streak_nxt = w_inc_ok ? w_streak_inc : '0;
            w_state_nxt  = (w_inc_ok && w_streak_inc == SW'(LOCK_CNT)) ? LOCKED : ACQ;
          end
          LOCKED: begin
            w_wrap_nxt   = w_inc_ok && (w_dec == 4'd0);
            w_serr_nxt   = !w_inc_ok;
            w_state_nxt  = w_inc_ok ? LOCKED : ACQ;
            w_streak_nxt = w_inc_ok ? r_streak : '0;
          end
          default: w_state_nxt = HUNT;
        endcase
      end
    end
  end

  // state, tracking and output-pulse registers
  always_ff @(posedge clk or negedge rst_syn) begin
    if (!rst_syn) begin
      r_state  <= HUNT;
      r_prev   <= 4'd0;
      r_digit  <= 4'd0;
      r_streak <= '0;
      r_valid  <= 1'b0;
      r_cerr   <= 1'b0;
      r_serr   <= 1'b0;
      r_wrap   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_prev   <= w_prev_nxt;
      r_digit  <= w_digit_nxt;
      r_streak <= w_streak_nxt;
      r_valid  <= w_valid_nxt;
      r_cerr   <= w_cerr_nxt;
      r_serr   <= w_serr_nxt;
      r_wrap   <= w_wrap_nxt;
    end
  end

  // saturating event counters, stuck at all-ones once full
  always_ff @(posedge clk or negedge rst_syn) begin
    if (!rst_syn) begin
      r_err_cnt  <= '0;
      r_wrap_cnt <= '0;
    end else begin
      if ((w_cerr_nxt || w_serr_nxt) && !(&r_err_cnt)) r_err_cnt <= r_err_cnt + CNT_W'(1);
      if (w_wrap_nxt && !(&r_wrap_cnt)) r_wrap_cnt <= r_wrap_cnt + CNT_W'(1);
    end
  end

  assign digit_out   = r_digit;
  assign digit_valid = r_valid;
  assign locked      = (r_state == LOCKED);
  assign code_err    = r_cerr;
  assign seq_err     = r_serr;
  assign wrap_pulse  = r_wrap;
  assign err_count   = r_err_cnt;
  assign wrap_count  = r_wrap_cnt;

endmodule

// File: tb/tb_bcd_seg_tracker.sv
// tb_bcd_seg_tracker: directed stimulus checked against a behavioural sequence model
module tb_bcd_seg_tracker;

  localparam int LOCK = 2;

  logic       clk = 1'b0;
  logic       rst_syn = 1'b0;
  logic       sample_en = 1'b0;
  logic [7:0] seg_in = 8'h00;
  logic [3:0] digit_out;
  logic       digit_valid, locked, code_err, seq_err, wrap_pulse;
  logic [7:0] err_count, wrap_count;

  bcd_seg_tracker #(.LOCK_CNT(LOCK), .CNT_W(8)) dut (
    .clk(clk), .rst_syn(rst_syn), .sample_en(sample_en), .seg_in(seg_in),
    .digit_out(digit_out), .digit_valid(digit_valid), .locked(locked),
    .code_err(code_err), .seq_err(seq_err), .wrap_pulse(wrap_pulse),
    .err_count(err_count), .wrap_count(wrap_count)
  );

  always #5 clk = ~clk;

  logic [7:0] pats [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  int m_mode, m_prev, m_streak, m_digit, m_errs, m_wraps;
  bit m_valid, m_cerr, m_serr, m_wrap;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int decode(input logic [7:0] s);
    for (int i = 0; i < 10; i++) if (s[6:0] == pats[i][6:0]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_streak = 0; m_digit = 0; m_errs = 0; m_wraps = 0;
    m_valid = 0; m_cerr = 0; m_serr = 0; m_wrap = 0;
  endtask

  task automatic model_step(input bit en, input logic [7:0] s);
    int d;
    bit good;
    m_valid = 0; m_cerr = 0; m_serr = 0; m_wrap = 0;
    if (!en) return;
    d = decode(s);
    if (d < 0) begin
      m_cerr = 1; m_mode = 0; m_streak = 0;
    end else begin
      m_valid = 1;
      m_digit = d;
      good = (d == (m_prev + 1) % 10);
      if (m_mode == 0) begin
        m_mode = 1; m_streak = 0;
      end else if (m_mode == 1) begin
        if (good) begin
          m_streak++;
          if (m_streak >= LOCK) m_mode = 2;
        end else m_streak = 0;
      end else begin
        if (good) m_wrap = (d == 0);
        else begin m_serr = 1; m_mode = 1; m_streak = 0; end
      end
      m_prev = d;
    end
    if ((m_cerr || m_serr) && m_errs < 255) m_errs++;
    if (m_wrap && m_wraps < 255) m_wraps++;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("digit_out", digit_out, m_digit);
      chk("digit_valid", digit_valid, m_valid);
      chk("locked", locked, m_mode == 2);
      chk("code_err", code_err, m_cerr);
      chk("seq_err", seq_err, m_serr);
      chk("wrap_pulse", wrap_pulse, m_wrap);
      chk("err_count", err_count, m_errs);
      chk("wrap_count", wrap_count, m_wraps);
    end
  end

  task automatic step(input bit en, input logic [7:0] s);
    sample_en = en;
    seg_in = s;
    @(posedge clk);
    model_step(en, s);
    @(negedge clk);
  endtask

  task automatic feed(input int d);
    step(1'b1, pats[d]);
  endtask

  initial begin
    model_reset();
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst digit_out", digit_out, 0);
    chk("rst locked", locked, 0);
    chk("rst err_count", err_count, 0);
    #1 rst_syn = 1'b1;
    @(negedge clk);

    for (int d = 0; d < 4; d++) begin
      feed(d);
      if (d == 1) chk("lit not locked at 1", locked, 0);
      if (d == 2) chk("lit locked at 2", locked, 1);
    end
    chk("lit digit 3", digit_out, 3);
    chk("lit no errs", err_count, 0);

    for (int d = 4; d < 10; d++) feed(d);
    feed(0);
    chk("lit wrap pulse", wrap_pulse, 1);
    chk("lit wrap_count", wrap_count, 1);
    feed(1); feed(2);
    step(1'b1, 8'hCF);
    chk("lit dp ignored", digit_out, 3);
    chk("lit locked at 3", locked, 1);

    feed(2);
    chk("lit seq_err", seq_err, 1);
    chk("lit unlocked", locked, 0);
    chk("lit err_count 1", err_count, 1);
    feed(3); feed(4);
    chk("lit relock", locked, 1);

    step(1'b1, 8'h00);
    chk("lit code_err", code_err, 1);
    chk("lit digit hold", digit_out, 4);
    chk("lit code unlock", locked, 0);
    chk("lit err_count 2", err_count, 2);

    for (int i = 0; i < 5; i++) step(1'b0, 8'($urandom));
    chk("lit idle err_count", err_count, 2);
    chk("lit idle valid", digit_valid, 0);

    feed(5); feed(5); feed(6); feed(7); feed(8); feed(8);

    for (int i = 0; i < 253; i++) step(1'b1, 8'h00);
    chk("lit err sat 255", err_count, 255);
    step(1'b1, 8'h81);
    chk("lit err stays 255", err_count, 255);
    chk("lit code_err again", code_err, 1);

    feed(1); feed(2); feed(3);
    chk("lit locked pre-reset", locked, 1);
    #2 rst_syn = 1'b0;
    #1 model_reset();
    chk("async digit_out", digit_out, 0);
    chk("async locked", locked, 0);
    chk("async err_count", err_count, 0);
    chk("async wrap_count", wrap_count, 0);
    @(negedge clk);
    #1 rst_syn = 1'b1;
    feed(7); feed(8); feed(9); feed(0);
    chk("lit post-reset lock", locked, 1);
    chk("lit post-reset wrap", wrap_count, 1);
    @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
